// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit:
// FSM states, instruction fields, ALU operation codes and next-PC selects.
package control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef logic [2:0] alu_code_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam alu_code_t ALU_ADD = 3'b000;
    localparam alu_code_t ALU_SUB = 3'b001;
    localparam alu_code_t ALU_AND = 3'b010;
    localparam alu_code_t ALU_OR  = 3'b011;
    localparam alu_code_t ALU_SLT = 3'b100;

    localparam logic [1:0] SEL_PC_INC    = 2'b00;
    localparam logic [1:0] SEL_PC_BRANCH = 2'b01;
    localparam logic [1:0] SEL_PC_JUMP   = 2'b10;

    // Instructions whose B operand comes from the sign-extended immediate.
    function automatic logic uses_sign_imm(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic uses_imm(input logic [5:0] op);
        return uses_sign_imm(op) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/control_multiciclo_alu_ctrl.sv
// Combinational decode of (opcode, funct) into an ALU operation code,
// flagging any opcode or R-type funct the datapath does not support.
module alu_ctrl
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_code_t  alu_op,
    output logic       invalid
);

    always_comb begin
        alu_op  = ALU_ADD;
        invalid = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: invalid = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
            OP_ANDI:               alu_op = ALU_AND;
            OP_ORI:                alu_op = ALU_OR;
            // beq compares by subtracting; zero comes back from the ALU
            OP_BEQ:                alu_op = ALU_SUB;
            OP_J:                  alu_op = ALU_ADD;
            default:               invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the MIPS-subset
// datapath; strobes are decoded from the current state and IR fields.
module control_multiciclo
    import control_pkg::*;
#(
    parameter int ALU_W = 3
)
(
    input  logic             reloj,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             sel_addr,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [1:0]       sel_pc,
    output logic             REG_RD,
    output logic             REG_WR,
    output logic             SEL_I,
    output logic             sel_b,
    output logic             reg_dst,
    output logic             sel_wb,
    output logic [ALU_W-1:0] alu_op,
    output logic             ilegal
);

    state_t    state;
    logic      ilegal_q;
    alu_code_t dec_op;
    logic      dec_invalid;

    alu_ctrl u_alu_ctrl (
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (dec_op),
        .invalid (dec_invalid)
    );

    // The ilegal flag is captured on the DECODE->EXEC edge so the pulse
    // lines up exactly with the EXEC cycle of the offending instruction.
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            ilegal_q <= 1'b0;
        end else begin
            ilegal_q <= (state == ST_DECODE) && dec_invalid;
            case (state)
                ST_FETCH: begin
                    if (mem_ack)
                        state <= ST_DECODE;
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    if (dec_invalid)
                        state <= ST_FETCH;
                    else begin
                        case (opcode)
                            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI: state <= ST_WB;
                            OP_LW, OP_SW:                       state <= ST_MEM;
                            default:                            state <= ST_FETCH;
                        endcase
                    end
                end
                ST_MEM: begin
                    if (mem_ack)
                        state <= (opcode == OP_LW) ? ST_WB : ST_FETCH;
                end
                ST_WB:   state <= ST_FETCH;
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign ilegal = ilegal_q;

    // There is no ALU output register, so the ALU operand selects stay
    // applied through MEM and WB to keep the address/result stable.
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        sel_addr = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        sel_pc   = SEL_PC_INC;
        REG_RD   = 1'b1;
        REG_WR   = 1'b1;
        SEL_I    = 1'b0;
        sel_b    = 1'b0;
        reg_dst  = 1'b0;
        sel_wb   = 1'b0;
        alu_op   = '0;
        if (reset) begin
            if ((state == ST_EXEC || state == ST_MEM || state == ST_WB) && !dec_invalid) begin
                alu_op = ALU_W'(dec_op);
                SEL_I  = uses_sign_imm(opcode);
                sel_b  = uses_imm(opcode);
            end
            case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        ir_wr  = 1'b1;
                        pc_wr  = 1'b1;
                        sel_pc = SEL_PC_INC;
                    end
                end
                ST_DECODE: REG_RD = 1'b0;
                ST_EXEC: begin
                    if (!dec_invalid) begin
                        case (opcode)
                            OP_BEQ: begin
                                pc_wr  = zero;
                                sel_pc = SEL_PC_BRANCH;
                            end
                            OP_J: begin
                                pc_wr  = 1'b1;
                                sel_pc = SEL_PC_JUMP;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    sel_addr = 1'b1;
                    mem_we   = (opcode == OP_SW);
                end
                ST_WB: begin
                    REG_WR  = 1'b0;
                    reg_dst = (opcode == OP_RTYPE);
                    sel_wb  = (opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: walks each instruction class cycle
// by cycle and compares strobes against hand-derived expectations.
module tb_control_multiciclo;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_ORI   = 6'b001101;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BAD   = 6'b111111;
    localparam logic [5:0] T_F_ADD = 6'b100000;
    localparam logic [5:0] T_F_BAD = 6'b000111;

    logic       reloj = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, sel_addr, ir_wr, pc_wr;
    logic [1:0] sel_pc;
    logic       REG_RD, REG_WR, SEL_I, sel_b, reg_dst, sel_wb, ilegal;
    logic [2:0] alu_op;

    int compared = 0;
    int mismatched = 0;

    control_multiciclo #(.ALU_W(3)) dut (
        .reloj    (reloj),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .sel_addr (sel_addr),
        .ir_wr    (ir_wr),
        .pc_wr    (pc_wr),
        .sel_pc   (sel_pc),
        .REG_RD   (REG_RD),
        .REG_WR   (REG_WR),
        .SEL_I    (SEL_I),
        .sel_b    (sel_b),
        .reg_dst  (reg_dst),
        .sel_wb   (sel_wb),
        .alu_op   (alu_op),
        .ilegal   (ilegal)
    );

    always #5 reloj = ~reloj;

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] expected);
        compared++;
        if (got !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn, input logic ack, input logic z);
        opcode  = op;
        funct   = fn;
        mem_ack = ack;
        zero    = z;
        #1;
    endtask

    // One clock: move past the rising edge, then drive this cycle's inputs.
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic ack, input logic z);
        @(posedge reloj);
        #1;
        apply_stimulus(op, fn, ack, z);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting control_multiciclo bench");
        apply_stimulus(T_RTYPE, T_F_ADD, 1'b1, 1'b0);
        repeat (2) @(posedge reloj);
        #1;
        check_output("rst_mem_req", 8'(mem_req), 8'd0);
        check_output("rst_reg_rd", 8'(REG_RD), 8'd1);
        check_output("rst_reg_wr", 8'(REG_WR), 8'd1);
        check_output("rst_ir_wr", 8'(ir_wr), 8'd0);
        check_output("rst_pc_wr", 8'(pc_wr), 8'd0);
        check_output("rst_ilegal", 8'(ilegal), 8'd0);
        apply_stimulus(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_output("rel_mem_req", 8'(mem_req), 8'd1);

        // add, zero-wait fetch
        cyc(T_RTYPE, T_F_ADD, 1'b1, 1'b0);
        check_output("add_f_req", 8'(mem_req), 8'd1);
        check_output("add_f_ir_wr", 8'(ir_wr), 8'd1);
        check_output("add_f_pc_wr", 8'(pc_wr), 8'd1);
        check_output("add_f_sel_pc", 8'(sel_pc), 8'd0);
        check_output("add_f_sel_addr", 8'(sel_addr), 8'd0);
        cyc(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        check_output("add_d_reg_rd", 8'(REG_RD), 8'd0);
        check_output("add_d_req", 8'(mem_req), 8'd0);
        cyc(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        check_output("add_e_alu_op", 8'(alu_op), 8'd0);
        check_output("add_e_sel_b", 8'(sel_b), 8'd0);
        check_output("add_e_reg_wr", 8'(REG_WR), 8'd1);
        cyc(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        check_output("add_wb_reg_wr", 8'(REG_WR), 8'd0);
        check_output("add_wb_reg_dst", 8'(reg_dst), 8'd1);
        check_output("add_wb_sel_wb", 8'(sel_wb), 8'd0);
        check_output("add_wb_req", 8'(mem_req), 8'd0);

        // lw with three wait cycles in MEM; stray acks in DECODE/EXEC
        cyc(T_LW, 6'd0, 1'b1, 1'b0);
        check_output("lw_f_req", 8'(mem_req), 8'd1);
        check_output("lw_f_reg_wr", 8'(REG_WR), 8'd1);
        cyc(T_LW, 6'd0, 1'b1, 1'b0);
        check_output("lw_d_reg_rd", 8'(REG_RD), 8'd0);
        cyc(T_LW, 6'd0, 1'b1, 1'b0);
        check_output("lw_e_sel_i", 8'(SEL_I), 8'd1);
        check_output("lw_e_sel_b", 8'(sel_b), 8'd1);
        check_output("lw_e_req", 8'(mem_req), 8'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(T_LW, 6'd0, (i == 3), 1'b0);
            check_output($sformatf("lw_m%0d_req", i), 8'(mem_req), 8'd1);
            check_output($sformatf("lw_m%0d_addr", i), 8'(sel_addr), 8'd1);
            check_output($sformatf("lw_m%0d_sel_i", i), 8'(SEL_I), 8'd1);
            check_output($sformatf("lw_m%0d_we", i), 8'(mem_we), 8'd0);
            check_output($sformatf("lw_m%0d_reg_wr", i), 8'(REG_WR), 8'd1);
        end
        cyc(T_LW, 6'd0, 1'b0, 1'b0);
        check_output("lw_wb_reg_wr", 8'(REG_WR), 8'd0);
        check_output("lw_wb_sel_wb", 8'(sel_wb), 8'd1);
        check_output("lw_wb_reg_dst", 8'(reg_dst), 8'd0);
        check_output("lw_wb_req", 8'(mem_req), 8'd0);
        cyc(T_SW, 6'd0, 1'b0, 1'b0);
        check_output("lw_next_req", 8'(mem_req), 8'd1);
        check_output("lw_next_reg_wr", 8'(REG_WR), 8'd1);
        check_output("fetch_wait_pc_wr", 8'(pc_wr), 8'd0);
        check_output("fetch_wait_ir_wr", 8'(ir_wr), 8'd0);

        // sw, zero wait in MEM
        cyc(T_SW, 6'd0, 1'b1, 1'b0);
        check_output("sw_f_ir_wr", 8'(ir_wr), 8'd1);
        cyc(T_SW, 6'd0, 1'b0, 1'b0);
        cyc(T_SW, 6'd0, 1'b0, 1'b0);
        check_output("sw_e_sel_i", 8'(SEL_I), 8'd1);
        cyc(T_SW, 6'd0, 1'b1, 1'b0);
        check_output("sw_m_req", 8'(mem_req), 8'd1);
        check_output("sw_m_we", 8'(mem_we), 8'd1);
        check_output("sw_m_addr", 8'(sel_addr), 8'd1);
        check_output("sw_m_reg_wr", 8'(REG_WR), 8'd1);

        // beq taken, then not taken
        for (int k = 0; k < 2; k++) begin
            cyc(T_BEQ, 6'd0, 1'b1, 1'b0);
            check_output($sformatf("beq%0d_f_req", k), 8'(mem_req), 8'd1);
            check_output($sformatf("beq%0d_f_we", k), 8'(mem_we), 8'd0);
            check_output($sformatf("beq%0d_f_addr", k), 8'(sel_addr), 8'd0);
            cyc(T_BEQ, 6'd0, 1'b0, (k == 0));
            check_output($sformatf("beq%0d_d_pc_wr", k), 8'(pc_wr), 8'd0);
            cyc(T_BEQ, 6'd0, 1'b0, (k == 0));
            check_output($sformatf("beq%0d_e_pc_wr", k), 8'(pc_wr), (k == 0) ? 8'd1 : 8'd0);
            check_output($sformatf("beq%0d_e_sel_pc", k), 8'(sel_pc), 8'd1);
            check_output($sformatf("beq%0d_e_alu_op", k), 8'(alu_op), 8'd1);
            check_output($sformatf("beq%0d_e_reg_wr", k), 8'(REG_WR), 8'd1);
        end

        // j
        cyc(T_J, 6'd0, 1'b1, 1'b0);
        check_output("j_f_req", 8'(mem_req), 8'd1);
        cyc(T_J, 6'd0, 1'b0, 1'b0);
        cyc(T_J, 6'd0, 1'b0, 1'b0);
        check_output("j_e_pc_wr", 8'(pc_wr), 8'd1);
        check_output("j_e_sel_pc", 8'(sel_pc), 8'd2);
        check_output("j_e_reg_wr", 8'(REG_WR), 8'd1);

        // ori then addi
        cyc(T_ORI, 6'd0, 1'b1, 1'b0);
        check_output("ori_f_req", 8'(mem_req), 8'd1);
        cyc(T_ORI, 6'd0, 1'b0, 1'b0);
        cyc(T_ORI, 6'd0, 1'b0, 1'b0);
        check_output("ori_e_sel_i", 8'(SEL_I), 8'd0);
        check_output("ori_e_sel_b", 8'(sel_b), 8'd1);
        check_output("ori_e_alu_op", 8'(alu_op), 8'd3);
        cyc(T_ORI, 6'd0, 1'b0, 1'b0);
        check_output("ori_wb_reg_wr", 8'(REG_WR), 8'd0);
        check_output("ori_wb_reg_dst", 8'(reg_dst), 8'd0);
        cyc(T_ADDI, 6'd0, 1'b1, 1'b0);
        check_output("addi_f_req", 8'(mem_req), 8'd1);
        cyc(T_ADDI, 6'd0, 1'b0, 1'b0);
        cyc(T_ADDI, 6'd0, 1'b0, 1'b0);
        check_output("addi_e_sel_i", 8'(SEL_I), 8'd1);
        check_output("addi_e_alu_op", 8'(alu_op), 8'd0);
        cyc(T_ADDI, 6'd0, 1'b0, 1'b0);
        check_output("addi_wb_reg_wr", 8'(REG_WR), 8'd0);
        check_output("addi_wb_sel_wb", 8'(sel_wb), 8'd0);

        // unsupported opcode, then unsupported R-type funct
        for (int k = 0; k < 2; k++) begin
            cyc((k == 0) ? T_BAD : T_RTYPE, T_F_BAD, 1'b1, 1'b0);
            check_output($sformatf("bad%0d_f_req", k), 8'(mem_req), 8'd1);
            cyc((k == 0) ? T_BAD : T_RTYPE, T_F_BAD, 1'b0, 1'b0);
            check_output($sformatf("bad%0d_d_ilegal", k), 8'(ilegal), 8'd0);
            cyc((k == 0) ? T_BAD : T_RTYPE, T_F_BAD, 1'b0, 1'b0);
            check_output($sformatf("bad%0d_e_ilegal", k), 8'(ilegal), 8'd1);
            check_output($sformatf("bad%0d_e_reg_wr", k), 8'(REG_WR), 8'd1);
            check_output($sformatf("bad%0d_e_req", k), 8'(mem_req), 8'd0);
            check_output($sformatf("bad%0d_e_pc_wr", k), 8'(pc_wr), 8'd0);
            cyc((k == 0) ? T_BAD : T_RTYPE, T_F_BAD, 1'b0, 1'b0);
            check_output($sformatf("bad%0d_n_ilegal", k), 8'(ilegal), 8'd0);
            check_output($sformatf("bad%0d_n_req", k), 8'(mem_req), 8'd1);
            check_output($sformatf("bad%0d_n_reg_wr", k), 8'(REG_WR), 8'd1);
        end

        // reset asserted while lw waits in MEM
        cyc(T_LW, 6'd0, 1'b1, 1'b0);
        cyc(T_LW, 6'd0, 1'b0, 1'b0);
        cyc(T_LW, 6'd0, 1'b0, 1'b0);
        cyc(T_LW, 6'd0, 1'b0, 1'b0);
        check_output("rmem_pre_req", 8'(mem_req), 8'd1);
        check_output("rmem_pre_addr", 8'(sel_addr), 8'd1);
        #1;
        reset = 1'b0;
        #1;
        check_output("rmem_req", 8'(mem_req), 8'd0);
        check_output("rmem_reg_rd", 8'(REG_RD), 8'd1);
        check_output("rmem_reg_wr", 8'(REG_WR), 8'd1);
        check_output("rmem_addr", 8'(sel_addr), 8'd0);
        cyc(T_LW, 6'd0, 1'b1, 1'b0);
        check_output("rhold_req", 8'(mem_req), 8'd0);
        check_output("rhold_ir_wr", 8'(ir_wr), 8'd0);
        apply_stimulus(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check_output("rrel_req", 8'(mem_req), 8'd1);
        check_output("rrel_addr", 8'(sel_addr), 8'd0);
        cyc(T_RTYPE, T_F_ADD, 1'b1, 1'b0);
        check_output("rrel_f_ir_wr", 8'(ir_wr), 8'd1);
        cyc(T_RTYPE, T_F_ADD, 1'b0, 1'b0);
        check_output("rrel_d_reg_rd", 8'(REG_RD), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
